// File: rtl/extmem_arb.sv
// extmem_arb: two-port arbiter for a single external memory.
//
// An instruction-side (read-only) port and a data-side (read/write) port share
// one memory. Each transaction runs IDLE -> BUSY -> RESP. A grant latches the
// requester's fields into registers. Ties are resolved round-robin, and the data
// side wins the first tie after reset. In BUSY the memory is enabled until
// mem_done arrives or TIMEOUT cycles have passed. In RESP the granted side gets
// a one-cycle ack together with rdata and err.
//
// Ports:
//   ph1, reset                 clock, synchronous active-high reset
//   i_req, i_adr, i_ack        instruction-side request / address / ack pulse
//   d_req, d_adr, d_rwb,       data-side request and transaction fields
//   d_byteen, d_wdata, d_ack   (d_rwb: 1 = read), ack pulse
//   rdata, err                 shared response data and timeout flag
//   mem_adr, mem_byteen,       registered memory command
//   mem_rwb, mem_wdata
//   mem_en, mem_oe             memory enable, write-data bus drive enable
//   mem_rdata, mem_done        memory read data and completion strobe
module extmem_arb #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        i_req,
    input  logic [10:0] i_adr,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [10:0] d_adr,
    input  logic        d_rwb,
    input  logic [3:0]  d_byteen,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [10:0] mem_adr,
    output logic [3:0]  mem_byteen,
    output logic        mem_rwb,
    output logic        mem_en,
    output logic [31:0] mem_wdata,
    output logic        mem_oe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        w_grant;
    logic        w_grant_d;
    logic        w_timeout;

    logic        r_gnt_d;    // current/last grant went to the data side
    logic        r_prio_d;   // data side wins the next tie
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [10:0] r_mem_adr;
    logic [3:0]  r_mem_byteen;
    logic        r_mem_rwb;
    logic [31:0] r_mem_wdata;

    assign w_timeout = (r_cnt == CntLast);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_grant_d   = d_req && (!i_req || r_prio_d);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_done || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gnt_d      <= 1'b0;
            r_prio_d     <= 1'b1;
            r_cnt        <= 8'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_mem_adr    <= 11'd0;
            r_mem_byteen <= 4'd0;
            r_mem_rwb    <= 1'b1;
            r_mem_wdata  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt_d  <= w_grant_d;
                r_prio_d <= !w_grant_d;
                r_cnt    <= 8'd0;
                if (w_grant_d) begin
                    r_mem_adr    <= d_adr;
                    r_mem_byteen <= d_byteen;
                    r_mem_rwb    <= d_rwb;
                    r_mem_wdata  <= d_wdata;
                end else begin
                    r_mem_adr    <= i_adr;
                    r_mem_byteen <= 4'b1111;
                    r_mem_rwb    <= 1'b1;
                end
            end
            if (r_state == BUSY) begin
                // A late mem_done in the final counted cycle still wins over timeout.
                if (mem_done) begin
                    r_rdata <= mem_rdata;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign i_ack      = (r_state == RESP) && !r_gnt_d;
    assign d_ack      = (r_state == RESP) && r_gnt_d;
    assign rdata      = r_rdata;
    assign err        = r_err;
    assign mem_adr    = r_mem_adr;
    assign mem_byteen = r_mem_byteen;
    assign mem_rwb    = r_mem_rwb;
    assign mem_wdata  = r_mem_wdata;
    assign mem_en     = (r_state == BUSY);
    assign mem_oe     = (r_state == BUSY) && !r_mem_rwb;

endmodule

// File: tb/tb_extmem_arb.sv
// Directed bench for extmem_arb with a response scoreboard.
module tb_extmem_arb;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        i_req;
    logic [10:0] i_adr;
    logic        i_ack;
    logic        d_req;
    logic [10:0] d_adr;
    logic        d_rwb;
    logic [3:0]  d_byteen;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] rdata;
    logic        err;
    logic [10:0] mem_adr;
    logic [3:0]  mem_byteen;
    logic        mem_rwb;
    logic        mem_en;
    logic [31:0] mem_wdata;
    logic        mem_oe;
    logic [31:0] mem_rdata;
    logic        mem_done;

    typedef struct {
        logic        side_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    extmem_arb #(.TIMEOUT(15)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .i_req      (i_req),
        .i_adr      (i_adr),
        .i_ack      (i_ack),
        .d_req      (d_req),
        .d_adr      (d_adr),
        .d_rwb      (d_rwb),
        .d_byteen   (d_byteen),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .rdata      (rdata),
        .err        (err),
        .mem_adr    (mem_adr),
        .mem_byteen (mem_byteen),
        .mem_rwb    (mem_rwb),
        .mem_en     (mem_en),
        .mem_wdata  (mem_wdata),
        .mem_oe     (mem_oe),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic side_d, input logic [31:0] rd, input logic e);
        exp_t x;
        x.side_d = side_d;
        x.rdata  = rd;
        x.err    = e;
        exp_q.push_back(x);
    endtask

    // Every ack must match the oldest outstanding expected response.
    always @(negedge ph1) begin
        if (!reset && (i_ack || d_ack)) begin
            exp_t x;
            check("ack_onehot", 32'(i_ack && d_ack), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                x = exp_q.pop_front();
                check("sb_side_d", 32'(d_ack), 32'(x.side_d));
                check("sb_rdata", rdata, x.rdata);
                check("sb_err", 32'(err), 32'(x.err));
            end
        end
    end

    initial begin
        int n;
        i_req = 0; i_adr = 0; d_req = 0; d_adr = 0; d_rwb = 1; d_byteen = 0; d_wdata = 0;
        mem_rdata = 0; mem_done = 0;

        // Reset state
        do_reset();
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_oe", 32'(mem_oe), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_adr", 32'(mem_adr), 32'd0);
        check("rst_mem_byteen", 32'(mem_byteen), 32'd0);
        check("rst_mem_rwb", 32'(mem_rwb), 32'd1);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        // Instruction read, mem_done immediately
        i_req = 1; i_adr = 11'h010; mem_done = 1; mem_rdata = 32'hDEADBEEF;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        check("i_busy_en", 32'(mem_en), 32'd1);
        check("i_busy_adr", 32'(mem_adr), 32'h010);
        check("i_busy_rwb", 32'(mem_rwb), 32'd1);
        check("i_busy_byteen", 32'(mem_byteen), 32'hF);
        check("i_busy_oe", 32'(mem_oe), 32'd0);
        tick();
        check("i_resp_ack", 32'(i_ack), 32'd1);
        check("i_resp_en", 32'(mem_en), 32'd0);
        i_req = 0;
        tick();
        check("i_idle_ack", 32'(i_ack), 32'd0);

        // Data write
        d_req = 1; d_rwb = 0; d_adr = 11'h7FF; d_byteen = 4'b0011; d_wdata = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        push(1'b1, 32'hCAFEF00D, 1'b0);
        tick();
        check("d_busy_oe", 32'(mem_oe), 32'd1);
        check("d_busy_rwb", 32'(mem_rwb), 32'd0);
        check("d_busy_byteen", 32'(mem_byteen), 32'h3);
        check("d_busy_wdata", mem_wdata, 32'h12345678);
        check("d_busy_adr", 32'(mem_adr), 32'h7FF);
        tick();
        check("d_resp_ack", 32'(d_ack), 32'd1);
        check("d_resp_oe", 32'(mem_oe), 32'd0);
        d_req = 0;
        tick();

        // Round-robin with both requests held
        do_reset();
        i_req = 1; i_adr = 11'h111;
        d_req = 1; d_adr = 11'h222; d_rwb = 1;
        for (int k = 0; k < 4; k++) begin
            logic side_d;
            side_d = (k % 2 == 0);
            mem_rdata = 32'hA0000000 + 32'(k);
            push(side_d, 32'hA0000000 + 32'(k), 1'b0);
            tick();
            check("rr_adr", 32'(mem_adr), side_d ? 32'h222 : 32'h111);
            tick();
            check("rr_d_ack", 32'(d_ack), 32'(side_d));
            check("rr_i_ack", 32'(i_ack), 32'(!side_d));
            if (k == 3) begin
                i_req = 0;
                d_req = 0;
            end
            tick();
            check("rr_ack_pulse", 32'(i_ack || d_ack), 32'd0);
        end
        tick();

        // Timeout: 15 BUSY cycles, then err with zero data
        mem_done = 0; mem_rdata = 32'hFFFFFFFF;
        d_req = 1; d_rwb = 1; d_adr = 11'h055;
        push(1'b1, 32'd0, 1'b1);
        tick();
        n = 0;
        while (mem_en && n < 40) begin
            n++;
            tick();
        end
        check("to_busy_cycles", 32'(n), 32'd15);
        check("to_d_ack", 32'(d_ack), 32'd1);
        check("to_err", 32'(err), 32'd1);
        d_req = 0;
        tick();

        // mem_done in the 15th BUSY cycle counts as success
        i_req = 1; i_adr = 11'h0F0;
        push(1'b0, 32'h55AA55AA, 1'b0);
        tick();
        for (int k = 0; k < 14; k++) tick();
        check("late_still_busy", 32'(mem_en), 32'd1);
        mem_done = 1; mem_rdata = 32'h55AA55AA;
        tick();
        check("late_i_ack", 32'(i_ack), 32'd1);
        check("late_err", 32'(err), 32'd0);
        mem_done = 0; i_req = 0;
        tick();

        // Reset during BUSY abandons the transaction
        d_req = 1; d_adr = 11'h333;
        tick();
        check("rb_busy", 32'(mem_en), 32'd1);
        reset = 1; d_req = 0;
        tick();
        reset = 0;
        check("rb_en", 32'(mem_en), 32'd0);
        check("rb_ack", 32'(i_ack || d_ack), 32'd0);
        tick();
        check("rb_ack2", 32'(i_ack || d_ack), 32'd0);
        i_req = 1; i_adr = 11'h444; d_req = 1; d_adr = 11'h555; mem_done = 1;
        mem_rdata = 32'h0BADF00D;
        push(1'b1, 32'h0BADF00D, 1'b0);
        tick();
        check("rb_tie_adr", 32'(mem_adr), 32'h555);
        tick();
        check("rb_tie_d_ack", 32'(d_ack), 32'd1);
        i_req = 0; d_req = 0; mem_done = 0;
        tick();

        // Delayed mem_done while the other side requests mid-BUSY
        i_req = 1; i_adr = 11'h0AB; mem_rdata = 32'h13579BDF;
        push(1'b0, 32'h13579BDF, 1'b0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("dl_en", 32'(mem_en), 32'd1);
            check("dl_adr_stable", 32'(mem_adr), 32'h0AB);
            if (k == 1) begin
                d_req = 1; d_adr = 11'h3C3; d_rwb = 1;
            end
            if (k == 4) mem_done = 1;
            tick();
        end
        check("dl_i_ack", 32'(i_ack), 32'd1);
        check("dl_no_d_ack", 32'(d_ack), 32'd0);
        mem_done = 0; i_req = 0; mem_rdata = 32'h2468ACE0;
        push(1'b1, 32'h2468ACE0, 1'b0);
        tick();
        check("dl_idle_en", 32'(mem_en), 32'd0);
        tick();
        check("dl_d_busy_adr", 32'(mem_adr), 32'h3C3);
        mem_done = 1;
        tick();
        check("dl_d_ack", 32'(d_ack), 32'd1);
        d_req = 0; mem_done = 0;
        tick();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/extmem_arb.md
EXTMEM_ARB -- requirements
Module: extmem_arb

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 15: maximum BUSY cycles waiting for mem_done before the transaction is aborted (legal range 1..255).

Interface
REQ-002 SHALL have port ph1, input, 1: single clock; all state updates on posedge ph1.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_req, input, 1: instruction-side read request, held high until i_ack.
REQ-005 SHALL have port i_adr, input, 11: instruction-side word address.
REQ-006 SHALL have port i_ack, output, 1: one-cycle completion pulse to the instruction side.
REQ-007 SHALL have port d_req, input, 1: data-side request, held high until d_ack.
REQ-008 SHALL have ports d_adr (input, 11), d_rwb (input, 1; 1=read), d_byteen (input, 4) and d_wdata (input, 32): data-side transaction fields.
REQ-009 SHALL have port d_ack, output, 1: one-cycle completion pulse to the data side.
REQ-010 SHALL have port rdata, output, 32: read data shared by both sides, valid only while i_ack or d_ack is high.
REQ-011 SHALL have port err, output, 1: high with the ack when the transaction timed out.
REQ-012 SHALL have ports mem_adr (output, 11), mem_byteen (output, 4), mem_rwb (output, 1), mem_en (output, 1), mem_wdata (output, 32) and mem_oe (output, 1; drive mem_wdata onto the memory data bus).
REQ-013 SHALL have ports mem_rdata (input, 32) and mem_done (input, 1).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-015 In IDLE with any request high, SHALL grant one requester, register its fields, and enter BUSY next cycle; with no request, SHALL stay in IDLE.
REQ-016 With only one request high, SHALL grant that requester; with both high, SHALL grant the side not granted last (round-robin).
REQ-017 After reset, the first tie SHALL go to the data side.
REQ-018 An instruction grant SHALL register mem_rwb=1 and mem_byteen=4'b1111.
REQ-019 A data grant SHALL register d_rwb, d_byteen and d_wdata.
REQ-020 SHALL drive mem_adr, mem_byteen, mem_rwb and mem_wdata from registers only, stable throughout BUSY.
REQ-021 In BUSY, SHALL assert mem_en=1, and SHALL assert mem_oe=~mem_rwb.
REQ-022 Outside BUSY, SHALL hold mem_en=0 and mem_oe=0.
REQ-023 In BUSY with mem_done=1 (sampled at the clock edge), SHALL register mem_rdata into rdata, clear err and enter RESP; minimum latency from request to ack is therefore 3 cycles.
REQ-024 SHALL run a BUSY cycle counter, cleared on entry to BUSY.
REQ-025 If mem_done stays 0 for TIMEOUT consecutive BUSY cycles, SHALL enter RESP with err=1 and rdata=0.
REQ-026 mem_done arriving in the same cycle as the timeout SHALL count as success.
REQ-027 In RESP, SHALL assert exactly the granted side's ack for one cycle, then return to IDLE.
REQ-028 SHALL ignore requests while in BUSY or RESP.
REQ-029 A requester SHALL be able to issue a new request in the cycle after its ack, so back-to-back transactions are possible.
REQ-030 SHALL keep rdata and err unchanged outside RESP.
REQ-031 A request dropped before ack is a protocol violation; SHALL still complete the granted transaction normally.

Reset
REQ-032 While reset is high at a clock edge, SHALL go to IDLE with i_ack=0, d_ack=0, err=0, mem_en=0, mem_oe=0, rdata=0, mem_adr=0, mem_byteen=0, mem_rwb=1, mem_wdata=0, counter=0 and round-robin pointer set so the data side wins the next tie.
REQ-033 Reset in BUSY or RESP SHALL abandon the transaction with no ack issued.

Verification
REQ-034 i_req=1, i_adr=0x010, mem_done tied 1, mem_rdata=0xDEADBEEF -> mem_en=1 with mem_adr=0x010 in cycle 2; i_ack=1, rdata=0xDEADBEEF, err=0 in cycle 3.
REQ-035 d_req=1, d_rwb=0, d_adr=0x7FF, d_byteen=4'b0011, d_wdata=0x12345678 -> in BUSY: mem_oe=1, mem_rwb=0, mem_byteen=4'b0011, mem_wdata=0x12345678; d_ack one cycle later.
REQ-036 i_req and d_req both held high continuously after reset -> grants alternate D, I, D, I over 4 transactions, and each ack is a single-cycle pulse.
REQ-037 mem_done held 0, TIMEOUT=15 -> exactly 15 BUSY cycles, then ack with err=1 and rdata=0; mem_done asserted in the 15th BUSY cycle gives err=0.
REQ-038 reset asserted during BUSY -> next cycle IDLE with mem_en=0, no ack, and the next tie grants the data side.
REQ-039 mem_done delayed 4 cycles while the other requester rises mid-BUSY -> the other request is not granted until the IDLE cycle after RESP, and mem_adr stays stable throughout BUSY.
